// File: rtl/wb_buffer_if.sv
// Producer handshake, regfile write port, bypass lookup and occupancy status
// of the write-back buffer, bundled as one interface.
interface wb_buffer_if #(
    parameter int width = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_addr;
    logic [width-1:0] in_data;

    logic             drain_en;
    logic             wr_enable;
    logic [4:0]       W_addr;
    logic [width-1:0] W_data;

    logic [4:0]       lk_addr;
    logic             lk_hit;
    logic [width-1:0] lk_data;

    logic [CW-1:0]    count;
    logic             empty;
    logic             full;

    // Producer and regfile side.
    modport master (
        output in_valid, in_addr, in_data, drain_en, lk_addr,
        input  in_ready, wr_enable, W_addr, W_data, lk_hit, lk_data,
               count, empty, full
    );

    // Buffer side.
    modport slave (
        input  in_valid, in_addr, in_data, drain_en, lk_addr,
        output in_ready, wr_enable, W_addr, W_data, lk_hit, lk_data,
               count, empty, full
    );
endinterface

// File: rtl/wb_buffer.sv
// In-order write-back FIFO of (addr, data) pairs draining into a regfile port.
// Define WB_BYPASS_EN to build the youngest-match bypass lookup.
module wb_buffer #(
    parameter int width = 32,
    parameter int DEPTH = 4
) (
    input logic       clk,
    input logic       reset,
    wb_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

    logic [4:0]       addr_mem [DEPTH];
    logic [width-1:0] data_mem [DEPTH];

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;

    logic empty;
    logic full;
    logic ready;
    logic push;
    logic pop;

    assign empty = (count == '0);
    assign full  = (count == CNT_MAX);
    assign ready = reset && !full;

    // Writes to x0 complete the handshake but never occupy an entry.
    assign push = bus.in_valid && ready && (bus.in_addr != 5'd0);
    // Gated by reset so entries flushed in a reset cycle never reach the regfile.
    assign pop  = reset && !empty && bus.drain_en;

    assign bus.in_ready  = ready;
    assign bus.wr_enable = pop;
    assign bus.W_addr    = empty ? 5'd0 : addr_mem[head];
    assign bus.W_data    = empty ? '0   : data_mem[head];
    assign bus.count     = count;
    assign bus.empty     = empty;
    assign bus.full      = full;

    always_ff @(posedge clk) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_ONE;
            if (pop)  head <= head + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: only occupied entries are ever observed.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail] <= bus.in_addr;
            data_mem[tail] <= bus.in_data;
        end
    end

`ifdef WB_BYPASS_EN
    logic             lk_hit;
    logic [width-1:0] lk_data;

    // Walk oldest to youngest so the last match, nearest the tail, wins.
    always_comb begin
        lk_hit  = 1'b0;
        lk_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.lk_addr != 5'd0 && i < int'(count) &&
                addr_mem[head + AW'(i)] == bus.lk_addr) begin
                lk_hit  = 1'b1;
                lk_data = data_mem[head + AW'(i)];
            end
        end
    end

    assign bus.lk_hit  = lk_hit;
    assign bus.lk_data = lk_data;
`else
    logic [4:0] unused_lk_addr;
    assign unused_lk_addr = bus.lk_addr;
    assign bus.lk_hit     = 1'b0;
    assign bus.lk_data    = '0;
`endif

endmodule

// File: tb/tb_wb_buffer.sv
// Self-checking bench for wb_buffer against a queue-based reference model.
module tb_wb_buffer;
    localparam int W  = 32;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;

    typedef struct {
        logic [4:0]   a;
        logic [W-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_buffer_if #(.width(W), .DEPTH(D)) bus();
    wb_buffer #(.width(W), .DEPTH(D)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    ent_t mq[$];      // model contents, oldest first
    ent_t exp_wr[$];  // regfile writes the model expects
    ent_t dut_wr[$];  // regfile writes the DUT produced

    function automatic bit m_ready();
        return reset === 1'b1 && mq.size() < D;
    endfunction

    function automatic bit m_wr();
        return reset === 1'b1 && mq.size() > 0 && bus.drain_en === 1'b1;
    endfunction

    function automatic logic [4:0] m_waddr();
        return (mq.size() > 0) ? mq[0].a : 5'd0;
    endfunction

    function automatic logic [W-1:0] m_wdata();
        return (mq.size() > 0) ? mq[0].d : '0;
    endfunction

    function automatic bit m_hit();
        bit h = 1'b0;
`ifdef WB_BYPASS_EN
        if (bus.lk_addr != 5'd0)
            foreach (mq[i]) if (mq[i].a == bus.lk_addr) h = 1'b1;
`endif
        return h;
    endfunction

    function automatic logic [W-1:0] m_lkdata();
        logic [W-1:0] v = '0;
`ifdef WB_BYPASS_EN
        if (bus.lk_addr != 5'd0)
            foreach (mq[i]) if (mq[i].a == bus.lk_addr) v = mq[i].d;
`endif
        return v;
    endfunction

    // One clock: record observed/expected regfile writes, then advance the model.
    task automatic step();
        bit   pop;
        bit   push;
        ent_t e;
        #1;
        pop  = m_wr();
        push = bus.in_valid === 1'b1 && m_ready() && bus.in_addr != 5'd0;
        if (bus.wr_enable === 1'b1) begin
            e.a = bus.W_addr;
            e.d = bus.W_data;
            dut_wr.push_back(e);
        end
        if (pop) exp_wr.push_back(mq[0]);
        e.a = bus.in_addr;
        e.d = bus.in_data;
        @(posedge clk);
        if (reset !== 1'b1) mq.delete();
        else begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(e);
        end
        #1;
    endtask

    task automatic clear_logs();
        exp_wr.delete();
        dut_wr.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.in_valid = 1'b1; bus.in_addr = 5'd9; bus.in_data = '1;
        bus.drain_en = 1'b1; bus.lk_addr = 5'd9;
        step(); step();
        checks++; if (bus.count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", bus.full); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        checks++; if (bus.wr_enable !== 1'b0) begin errors++; $display("FAIL reset_wr_enable: got %b expected 0", bus.wr_enable); end
        checks++; if (bus.W_addr !== 5'd0 || bus.W_data !== '0) begin errors++; $display("FAIL reset_W: got %0h/%0h expected 0/0", bus.W_addr, bus.W_data); end
        checks++; if (bus.lk_hit !== 1'b0 || bus.lk_data !== '0) begin errors++; $display("FAIL reset_lk: got %b/%0h expected 0/0", bus.lk_hit, bus.lk_data); end
        reset = 1'b1; bus.in_valid = 1'b0; bus.drain_en = 1'b0; bus.lk_addr = 5'd0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_single();
        clear_logs();
        bus.in_valid = 1'b1; bus.in_addr = 5'd5; bus.in_data = 32'hAAAA; bus.drain_en = 1'b0;
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.count !== CW'(1)) begin errors++; $display("FAIL single_count: got %0d expected 1", bus.count); end
        checks++; if (bus.wr_enable !== 1'b0) begin errors++; $display("FAIL single_hold: got %b expected 0", bus.wr_enable); end
        bus.drain_en = 1'b1;
        #1;
        checks++; if (bus.wr_enable !== 1'b1) begin errors++; $display("FAIL single_wr_enable: got %b expected 1", bus.wr_enable); end
        checks++; if (bus.W_addr !== 5'd5 || bus.W_data !== 32'hAAAA) begin errors++; $display("FAIL single_W: got %0h/%0h expected 5/aaaa", bus.W_addr, bus.W_data); end
        step();
        checks++; if (bus.empty !== 1'b1 || bus.wr_enable !== 1'b0) begin errors++; $display("FAIL single_drained: got empty=%b wr=%b expected 1/0", bus.empty, bus.wr_enable); end
        bus.drain_en = 1'b0;
    endtask

    task automatic test_full();
        clear_logs();
        bus.drain_en = 1'b0;
        for (int a = 1; a <= 5; a++) begin
            bus.in_valid = 1'b1; bus.in_addr = 5'(a); bus.in_data = $urandom;
            #1;
            checks++;
            if (bus.in_ready !== (a <= 4)) begin errors++; $display("FAIL full_ready_%0d: got %b expected %b", a, bus.in_ready, (a <= 4)); end
            step();
        end
        checks++; if (bus.count !== CW'(4) || bus.full !== 1'b1) begin errors++; $display("FAIL full_state: got count=%0d full=%b expected 4/1", bus.count, bus.full); end
        step();
        checks++; if (bus.count !== CW'(4)) begin errors++; $display("FAIL full_hold: got %0d expected 4", bus.count); end
        bus.drain_en = 1'b1;
        step();  // full: pop only
        checks++; if (bus.count !== CW'(3)) begin errors++; $display("FAIL full_pop_no_push: got %0d expected 3", bus.count); end
        step();  // 5th accepted alongside a pop
        checks++; if (bus.count !== CW'(3)) begin errors++; $display("FAIL full_push_pop: got %0d expected 3", bus.count); end
        bus.in_valid = 1'b0;
        repeat (4) step();
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL full_drain_empty: got %b expected 1", bus.empty); end
        checks++; if (dut_wr.size() != 5) begin errors++; $display("FAIL full_write_count: got %0d expected 5", dut_wr.size()); end
        for (int i = 0; i < 5 && i < dut_wr.size(); i++) begin
            checks++;
            if (dut_wr[i].a !== 5'(i + 1)) begin errors++; $display("FAIL full_order_%0d: got %0d expected %0d", i, dut_wr[i].a, i + 1); end
        end
        bus.drain_en = 1'b0;
    endtask

    task automatic test_lookup();
        bit           byp;
        logic [W-1:0] exp_d;
`ifdef WB_BYPASS_EN
        byp = 1'b1;
`else
        byp = 1'b0;
`endif
        clear_logs();
        bus.drain_en = 1'b0; bus.in_valid = 1'b1; bus.in_addr = 5'd3;
        bus.in_data = 32'h11; step();
        bus.in_data = 32'h22; step();
        bus.in_valid = 1'b0; bus.lk_addr = 5'd3;
        exp_d = byp ? 32'h22 : 32'h0;
        #1;
        checks++; if (bus.lk_hit !== byp || bus.lk_data !== exp_d) begin errors++; $display("FAIL lk_youngest: got %b/%0h expected %b/%0h", bus.lk_hit, bus.lk_data, byp, exp_d); end
        bus.in_valid = 1'b1; bus.in_data = 32'h33;
        #1;
        checks++; if (bus.lk_data !== exp_d) begin errors++; $display("FAIL lk_excl_incoming: got %0h expected %0h", bus.lk_data, exp_d); end
        bus.in_valid = 1'b0; bus.lk_addr = 5'd0;
        #1;
        checks++; if (bus.lk_hit !== 1'b0 || bus.lk_data !== '0) begin errors++; $display("FAIL lk_zero: got %b/%0h expected 0/0", bus.lk_hit, bus.lk_data); end
        bus.lk_addr = 5'd3; bus.drain_en = 1'b1;
        step();
        #1;
        checks++; if (bus.lk_hit !== byp || bus.lk_data !== exp_d) begin errors++; $display("FAIL lk_draining_head: got %b/%0h expected %b/%0h", bus.lk_hit, bus.lk_data, byp, exp_d); end
        step();
        checks++; if (bus.lk_hit !== 1'b0) begin errors++; $display("FAIL lk_after_drain: got %b expected 0", bus.lk_hit); end
        bus.drain_en = 1'b0; bus.lk_addr = 5'd0;
    endtask

    task automatic test_addr0();
        clear_logs();
        bus.in_valid = 1'b1; bus.in_addr = 5'd0; bus.in_data = 32'hFFFF; bus.drain_en = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL addr0_ready: got %b expected 1", bus.in_ready); end
        step(); step();
        checks++; if (bus.count !== '0) begin errors++; $display("FAIL addr0_count: got %0d expected 0", bus.count); end
        checks++; if (dut_wr.size() != 0) begin errors++; $display("FAIL addr0_written: got %0d writes expected 0", dut_wr.size()); end
        bus.in_valid = 1'b0; bus.drain_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        clear_logs();
        bus.drain_en = 1'b0; bus.in_valid = 1'b1;
        repeat (2) begin
            bus.in_addr = 5'($urandom_range(1, 31)); bus.in_data = $urandom; step();
        end
        bus.in_addr = 5'($urandom_range(1, 31)); bus.in_data = $urandom; bus.drain_en = 1'b1;
        step();
        checks++; if (bus.count !== CW'(2)) begin errors++; $display("FAIL b2b_count: got %0d expected 2", bus.count); end
        for (int c = 0; c < 10; c++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_addr  = 5'($urandom_range(0, 31));
            bus.in_data  = $urandom;
            bus.drain_en = 1'($urandom_range(0, 1));
            step();
            checks++; if (bus.count !== CW'(mq.size())) begin errors++; $display("FAIL b2b_mixed_%0d: got %0d expected %0d", c, bus.count, mq.size()); end
        end
        bus.in_valid = 1'b0; bus.drain_en = 1'b1;
        repeat (D + 1) step();
        checks++; if (dut_wr.size() != exp_wr.size()) begin errors++; $display("FAIL b2b_writes: got %0d expected %0d", dut_wr.size(), exp_wr.size()); end
        for (int i = 0; i < exp_wr.size() && i < dut_wr.size(); i++) begin
            checks++;
            if (dut_wr[i].a !== exp_wr[i].a || dut_wr[i].d !== exp_wr[i].d) begin
                errors++; $display("FAIL b2b_order_%0d: got %0h/%0h expected %0h/%0h", i, dut_wr[i].a, dut_wr[i].d, exp_wr[i].a, exp_wr[i].d);
            end
        end
        bus.drain_en = 1'b0;
    endtask

    task automatic test_reset_flush();
        clear_logs();
        bus.drain_en = 1'b0; bus.in_valid = 1'b1;
        for (int a = 7; a <= 9; a++) begin
            bus.in_addr = 5'(a); bus.in_data = $urandom; step();
        end
        bus.in_valid = 1'b0;
        checks++; if (bus.count !== CW'(3)) begin errors++; $display("FAIL flush_queued: got %0d expected 3", bus.count); end
        reset = 1'b0; step(); reset = 1'b1;
        checks++; if (bus.count !== '0 || bus.empty !== 1'b1) begin errors++; $display("FAIL flush_count: got %0d expected 0", bus.count); end
        bus.drain_en = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (bus.wr_enable !== 1'b0) begin errors++; $display("FAIL flush_wr_%0d: got %b expected 0", c, bus.wr_enable); end
            step();
        end
        checks++; if (dut_wr.size() != 0) begin errors++; $display("FAIL flush_written: got %0d writes expected 0", dut_wr.size()); end
        bus.drain_en = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset        = ($urandom_range(0, 49) != 0);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_addr  = 5'($urandom_range(0, 7));
            bus.in_data  = $urandom;
            bus.drain_en = ($urandom_range(0, 2) == 0);
            bus.lk_addr  = 5'($urandom_range(0, 7));
            #1;
            checks++;
            if (bus.count !== CW'(mq.size()) || bus.empty !== (mq.size() == 0) || bus.full !== (mq.size() == D)) begin
                errors++; $display("FAIL rnd_status_%0d: got count=%0d empty=%b full=%b expected count=%0d", c, bus.count, bus.empty, bus.full, mq.size());
            end
            checks++;
            if (bus.in_ready !== m_ready() || bus.wr_enable !== m_wr()) begin
                errors++; $display("FAIL rnd_handshake_%0d: got ready=%b wr=%b expected %b/%b", c, bus.in_ready, bus.wr_enable, m_ready(), m_wr());
            end
            checks++;
            if (bus.W_addr !== m_waddr() || bus.W_data !== m_wdata()) begin
                errors++; $display("FAIL rnd_W_%0d: got %0h/%0h expected %0h/%0h", c, bus.W_addr, bus.W_data, m_waddr(), m_wdata());
            end
            checks++;
            if (bus.lk_hit !== m_hit() || bus.lk_data !== m_lkdata()) begin
                errors++; $display("FAIL rnd_lk_%0d: got %b/%0h expected %b/%0h", c, bus.lk_hit, bus.lk_data, m_hit(), m_lkdata());
            end
            step();
        end
        reset = 1'b1; bus.in_valid = 1'b0; bus.drain_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_data = '0;
        bus.drain_en = 1'b0; bus.lk_addr = '0;
        test_reset();
        test_single();
        test_full();
        test_lookup();
        test_addr0();
        test_back_to_back();
        test_reset_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
